// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter slice.
package wb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } ld_funct3_e;

    // One buffered load return; valid clears when a younger ALU write kills it.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
        logic [2:0]            funct3;
        logic [1:0]            offset;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_ext.sv
// Combinational sub-word load extender; only built when WB_LOAD_EXT_EN is defined.
`ifdef WB_LOAD_EXT_EN
module wb_load_ext
    import wb_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    output logic [XLEN-1:0] ext_data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = data[{offset, 3'b000} +: 8];
        half_sel   = data[{offset[1], 4'b0000} +: 16];
        ext_data_c = data;
        case (funct3)
            LB:      ext_data_c = {{24{byte_sel[7]}}, byte_sel};
            LH:      ext_data_c = {{16{half_sel[15]}}, half_sel};
            LBU:     ext_data_c = {24'h000000, byte_sel};
            LHU:     ext_data_c = {16'h0000, half_sel};
            default: ext_data_c = data;
        endcase
    end

endmodule
`endif

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: ALU priority, buffered load returns with anti-starvation.
// Optional sub-word load extension is enabled by defining WB_LOAD_EXT_EN.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  alu_valid_i,
    output logic                  alu_ready_o,
    input  logic [REG_ADDR_W-1:0] alu_rd_i,
    input  logic [XLEN-1:0]       alu_data_i,
    input  logic                  ld_valid_i,
    output logic                  ld_ready_o,
    input  logic [REG_ADDR_W-1:0] ld_rd_i,
    input  logic [XLEN-1:0]       ld_data_i,
    input  logic [2:0]            ld_funct3_i,
    input  logic [1:0]            ld_offset_i,
    output logic                  rd_wren_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic [XLEN-1:0]       rd_data_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    wb_entry_t        fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] starve_cnt_q;

    logic            empty_c;
    logic            full_c;
    logic            alu_issue_c;
    logic            deq_c;
    logic            ld_issue_c;
    logic            enq_c;
    wb_entry_t       head_c;
    wb_entry_t       enq_entry_c;
    logic [XLEN-1:0] head_data_c;

    // Pointer MSB disambiguates full from empty on wrap-around.
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

    assign ld_ready_o  = !full_c;
    assign alu_ready_o = (starve_cnt_q < CNT_W'(STARVE_MAX));
    assign head_c      = fifo_q[rd_ptr_q[IDX_W-1:0]];

    // x0 writes are accepted but never reach the register file.
    assign alu_issue_c = alu_valid_i && alu_ready_o && (alu_rd_i != '0);
    assign deq_c       = !empty_c && !alu_issue_c;
    assign ld_issue_c  = deq_c && head_c.valid;
    assign enq_c       = ld_valid_i && !full_c && (ld_rd_i != '0);

`ifdef WB_LOAD_EXT_EN
    always_comb begin
        enq_entry_c        = '0;
        enq_entry_c.valid  = 1'b1;
        enq_entry_c.rd     = ld_rd_i;
        enq_entry_c.data   = ld_data_i;
        enq_entry_c.funct3 = ld_funct3_i;
        enq_entry_c.offset = ld_offset_i;
    end

    wb_load_ext u_load_ext (
        .data       (head_c.data),
        .funct3     (head_c.funct3),
        .offset     (head_c.offset),
        .ext_data_c (head_data_c)
    );
`else
    always_comb begin
        enq_entry_c       = '0;
        enq_entry_c.valid = 1'b1;
        enq_entry_c.rd    = ld_rd_i;
        enq_entry_c.data  = ld_data_i;
    end

    assign head_data_c = head_c.data;

    // Extension fields are carried by the LSU in this build and never consumed here.
    logic unused_ld_fields;
    assign unused_ld_fields = ^{ld_funct3_i, ld_offset_i, head_c.funct3, head_c.offset};
`endif

    // Storage: an issued ALU write kills older buffered loads to the same rd.
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (alu_issue_c && (fifo_q[IDX_W'(i)].rd == alu_rd_i)) begin
                fifo_q[IDX_W'(i)].valid <= 1'b0;
            end
        end
        if (enq_c) begin
            fifo_q[wr_ptr_q[IDX_W-1:0]] <= enq_entry_c;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            starve_cnt_q <= '0;
        end else begin
            if (enq_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (deq_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (empty_c || deq_c) begin
                starve_cnt_q <= '0;
            end else begin
                starve_cnt_q <= starve_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_wren_o <= 1'b0;
            rd_addr_o <= '0;
            rd_data_o <= '0;
        end else begin
            rd_wren_o <= alu_issue_c || ld_issue_c;
            if (alu_issue_c) begin
                rd_addr_o <= alu_rd_i;
                rd_data_o <= alu_data_i;
            end else if (ld_issue_c) begin
                rd_addr_o <= head_c.rd;
                rd_data_o <= head_data_c;
            end
        end
    end

endmodule
